// File: rtl/efuse_pkg.sv
// Shared types and sizing for the eFuse macro emulator.
package efuse_pkg;

    localparam int FUSE_BITS  = 256;
    localparam int FUSE_BYTES = 32;
    localparam int CNT_W      = 10;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PGM,
        ST_PGM_AEN,
        ST_RD,
        ST_RD_AEN
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/efuse_macro_emu_if.sv
// Controller-to-macro signal bundle; master is the fuse controller, slave is the macro.
interface efuse_macro_emu_if
    import efuse_pkg::*;
;
    logic                 efuse_pgmen;
    logic                 efuse_rden;
    logic                 efuse_aen;
    logic [7:0]           efuse_addr;
    logic [7:0]           efuse_rdata;
    logic                 emu_err_timing;
    logic                 emu_err_proto;
    logic                 emu_busy;
    logic [FUSE_BITS-1:0] emu_fuse_map;

    modport master (
        output efuse_pgmen, efuse_rden, efuse_aen, efuse_addr,
        input  efuse_rdata, emu_err_timing, emu_err_proto, emu_busy, emu_fuse_map
    );

    modport slave (
        input  efuse_pgmen, efuse_rden, efuse_aen, efuse_addr,
        output efuse_rdata, emu_err_timing, emu_err_proto, emu_busy, emu_fuse_map
    );

endinterface

// File: rtl/efuse_aen_timer.sv
// Access-strobe edge detector plus saturating pulse-width counter.
// At the falling-edge cycle o_count equals the number of cycles aen was high.
module efuse_aen_timer
    import efuse_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_aen,
    output logic             o_aen_rise,
    output logic             o_aen_fall,
    output logic [CNT_W-1:0] o_count
);

    logic             r_aen_q;
    logic [CNT_W-1:0] r_count;

    assign o_aen_rise = i_aen & ~r_aen_q;
    assign o_aen_fall = ~i_aen & r_aen_q;
    assign o_count    = r_count;

    // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_aen_q <= 1'b0;
            r_count <= '0;
        end else begin
            r_aen_q <= i_aen;
            if (o_aen_rise) begin
                r_count <= CNT_W'(1);
            end else if (i_aen) begin
                r_count <= sat_inc(r_count);
            end
        end
    end

endmodule

// File: rtl/efuse_macro_emu.sv
// Behavioural emulator of a 256-bit OTP eFuse macro: timed program/read pulses,
// protocol and timing checks, debug view of the whole array.
module efuse_macro_emu
    import efuse_pkg::*;
#(
    parameter int unsigned          TPGM_MIN = 3,
    parameter int unsigned          TRD_MIN  = 3,
    parameter logic [FUSE_BITS-1:0] INIT     = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    efuse_macro_emu_if.slave  bus
);

    localparam logic [CNT_W-1:0] PGM_LIM = CNT_W'(TPGM_MIN);
    localparam logic [CNT_W-1:0] RD_LIM  = CNT_W'(TRD_MIN);

    state_t               r_state;
    logic [7:0]           r_addr;
    logic                 r_abort;
    logic                 r_both_q;
    logic [FUSE_BITS-1:0] r_fuse_map;
    logic [7:0]           r_rdata;
    logic                 r_err_timing;
    logic                 r_err_proto;

    state_t               w_next_state;
    logic                 w_aen_rise;
    logic                 w_aen_fall;
    logic [CNT_W-1:0]     w_count;
    logic                 w_both;
    logic                 w_addr_moved;
    logic                 w_capture;
    logic                 w_set_abort;
    logic                 w_prog;
    logic                 w_rd_ok;
    logic                 w_rd_fail;
    logic                 w_err_proto;
    logic                 w_err_timing;

    efuse_aen_timer u_aen_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_aen      (bus.efuse_aen),
        .o_aen_rise (w_aen_rise),
        .o_aen_fall (w_aen_fall),
        .o_count    (w_count)
    );

    assign w_both       = bus.efuse_pgmen & bus.efuse_rden;
    // Only the first address change of an access is flagged; later ones are already covered.
    assign w_addr_moved = bus.efuse_aen & (bus.efuse_addr != r_addr) & ~r_abort;

    // NOTE: every output of this block gets a default first, otherwise latches are inferred.
    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_set_abort  = 1'b0;
        w_prog       = 1'b0;
        w_rd_ok      = 1'b0;
        w_rd_fail    = 1'b0;
        w_err_proto  = 1'b0;
        w_err_timing = 1'b0;

        if (w_both) begin
            w_err_proto  = ~r_both_q;
            w_next_state = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (bus.efuse_aen) begin
                        w_err_proto = w_aen_rise;
                    end else if (bus.efuse_pgmen) begin
                        w_next_state = ST_PGM;
                    end else if (bus.efuse_rden) begin
                        w_next_state = ST_RD;
                    end
                end
                ST_PGM: begin
                    if (!bus.efuse_pgmen) begin
                        w_err_proto  = bus.efuse_aen;
                        w_next_state = ST_IDLE;
                    end else if (bus.efuse_aen) begin
                        w_capture    = 1'b1;
                        w_next_state = ST_PGM_AEN;
                    end
                end
                ST_PGM_AEN: begin
                    if (!bus.efuse_pgmen) begin
                        w_err_proto  = ~r_abort;
                        w_next_state = ST_IDLE;
                    end else if (w_aen_fall) begin
                        w_next_state = ST_PGM;
                        if (!r_abort) begin
                            w_prog       = (w_count >= PGM_LIM);
                            w_err_timing = (w_count <  PGM_LIM);
                        end
                    end else if (w_addr_moved) begin
                        w_err_proto = 1'b1;
                        w_set_abort = 1'b1;
                    end
                end
                ST_RD: begin
                    if (!bus.efuse_rden) begin
                        w_err_proto  = bus.efuse_aen;
                        w_next_state = ST_IDLE;
                    end else if (bus.efuse_aen) begin
                        w_capture    = 1'b1;
                        w_next_state = ST_RD_AEN;
                    end
                end
                ST_RD_AEN: begin
                    if (!bus.efuse_rden) begin
                        w_err_proto  = ~r_abort;
                        w_next_state = ST_IDLE;
                    end else if (w_aen_fall) begin
                        w_next_state = ST_RD;
                        if (!r_abort) begin
                            w_rd_ok      = (w_count >= RD_LIM);
                            w_rd_fail    = (w_count <  RD_LIM);
                            w_err_timing = (w_count <  RD_LIM);
                        end
                    end else if (w_addr_moved) begin
                        w_err_proto = 1'b1;
                        w_set_abort = 1'b1;
                    end
                end
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    // NOTE: the fuse array is reset on purpose; it models the macro reloading its content at reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_abort      <= 1'b0;
            r_both_q     <= 1'b0;
            r_fuse_map   <= INIT;
            r_rdata      <= '0;
            r_err_timing <= 1'b0;
            r_err_proto  <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_both_q     <= w_both;
            r_err_timing <= w_err_timing;
            r_err_proto  <= w_err_proto;

            if (w_capture) begin
                r_addr  <= bus.efuse_addr;
                r_abort <= 1'b0;
            end else if (w_set_abort) begin
                r_abort <= 1'b1;
            end

            if (w_prog) begin
                r_fuse_map[r_addr] <= 1'b1;
            end

            if (w_rd_ok) begin
                r_rdata <= r_fuse_map[{r_addr[7:3], 3'b000} +: 8];
            end else if (w_rd_fail) begin
                r_rdata <= 8'h00;
            end
        end
    end

    assign bus.efuse_rdata    = r_rdata;
    assign bus.emu_err_timing = r_err_timing;
    assign bus.emu_err_proto  = r_err_proto;
    assign bus.emu_busy       = (r_state != ST_IDLE);
    assign bus.emu_fuse_map   = r_fuse_map;

endmodule

// File: doc/efuse_macro_emu.md
EFUSE_MACRO_EMU -- requirements
Module: efuse_macro_emu

Interface
REQ-001 Parameter TPGM_MIN, default 3, minimum aen-high cycles for a valid program pulse.
REQ-002 Parameter TRD_MIN, default 3, minimum aen-high cycles for a valid read pulse.
REQ-003 Parameter INIT, default 256'h0, array content loaded at reset.
REQ-004 clk  in  1  single block clock.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 efuse_pgmen  in  1  program-mode enable from controller.
REQ-007 efuse_rden  in  1  read-mode enable from controller.
REQ-008 efuse_aen  in  1  access strobe; pulse width is timed.
REQ-009 efuse_addr  in  8  bit address (program); addr[7:3] byte address (read).
REQ-010 efuse_rdata  out  8  read byte returned to controller.
REQ-011 emu_err_timing  out  1  one-cycle pulse, aen pulse shorter than minimum.
REQ-012 emu_err_proto  out  1  one-cycle pulse, protocol violation.
REQ-013 emu_busy  out  1  high while a pgmen/rden access is open.
REQ-014 emu_fuse_map  out  256  current array content, for debug/scoreboard.

Function
REQ-015 Array shall be 256 one-time-programmable bits; bit order: byte b = bits [8b+7:8b].
REQ-016 FSM states IDLE, PGM, PGM_AEN, RD, RD_AEN; emu_busy = (state != IDLE).
REQ-017 IDLE->PGM when pgmen=1, rden=0, aen=0; IDLE->RD when rden=1, pgmen=0, aen=0.
REQ-018 pgmen=1 and rden=1 in same cycle, in any state: emu_err_proto pulse, FSM->IDLE, no array/rdata update.
REQ-019 aen=1 in IDLE (no mode enable): emu_err_proto pulse, ignored.
REQ-020 PGM->PGM_AEN and RD->RD_AEN on aen rise; address captured that cycle; 10-bit saturating width counter cleared then increments each aen-high cycle.
REQ-021 efuse_addr change while in *_AEN: emu_err_proto pulse, access aborted on aen fall (no update).
REQ-022 On aen fall in PGM_AEN: if count >= TPGM_MIN, captured bit set to 1; else emu_err_timing pulse, no change; return to PGM.
REQ-023 Programming shall only set bits 0->1; programming an already-set bit is a legal no-op.
REQ-024 On aen fall in RD_AEN: if count >= TRD_MIN, efuse_rdata <= captured byte next cycle (1-cycle latency after aen fall); else efuse_rdata <= 8'h00 and emu_err_timing pulse; return to RD.
REQ-025 efuse_rdata shall hold its value until the next completed read or reset.
REQ-026 PGM/RD->IDLE when its mode enable drops with aen=0; enable dropping while aen=1: emu_err_proto, abort, ->IDLE.
REQ-027 Counter saturates at 1023; saturation is not an error.
REQ-028 emu_err_* are single-cycle pulses; both may not assert for the same access (proto wins).

Reset
REQ-029 On rst_n=0 at clk edge: state IDLE, counter 0, efuse_rdata 8'h00, emu_err_* 0, emu_busy 0, array = INIT.
REQ-030 Reset mid-access shall discard the access with no array update.

Structure
REQ-031 Package efuse_pkg holds FSM state enum, array size 256, byte count 32, counter width 10.
REQ-032 Sub-module efuse_aen_timer: aen edge detect plus saturating width counter; FSM and array stay in top.

Verification
REQ-033 Reset with INIT=256'h...f0 in byte0; rden=1, addr=8'h00, aen 3 cycles -> rdata=8'hf0 one cycle after aen fall.
REQ-034 pgmen=1, addr=8'h0A, aen 3 cycles -> emu_fuse_map[10]=1; read addr 8'h08 -> rdata=8'h04.
REQ-035 pgmen=1, aen 2 cycles, addr 8'h11 -> emu_err_timing pulse, bit 17 stays 0.
REQ-036 pgmen=1 and rden=1 together -> emu_err_proto pulse, state IDLE, rdata unchanged.
REQ-037 Program 64 bits of byte range 8..15 with 64'hf0f1f2f3f4f5f6f7 pattern, then read bytes 8..15 -> matches; re-program same bits -> no change, no error.
REQ-038 rst_n low during PGM_AEN -> no bit set, all outputs at reset values next cycle.
